// File: rtl/pc_seq_ctrl_if.sv
// Datapath-facing bundle of the PC sequencer: ROM fetch, decode inputs, ALU flags and link/status outputs.
// The master modport is the sequencer side; the slave modport is the surrounding datapath.
interface pc_seq_ctrl_if #(
    parameter int PC_W = 10
);
    logic            stall;
    logic [31:0]     instr;
    logic [31:0]     imm;
    logic [31:0]     rs1_val;
    logic            alu_zero;
    logic            alu_lt;
    logic            alu_ltu;
    logic [PC_W-3:0] imem_addr;
    logic [PC_W-1:0] pc;
    logic            link_we;
    logic [31:0]     link_data;
    logic            br_taken;
    logic            halted;
    logic            fault;
    logic [31:0]     instret;

    modport master (
        input  stall, instr, imm, rs1_val, alu_zero, alu_lt, alu_ltu,
        output imem_addr, pc, link_we, link_data, br_taken, halted, fault, instret
    );

    modport slave (
        output stall, instr, imm, rs1_val, alu_zero, alu_lt, alu_ltu,
        input  imem_addr, pc, link_we, link_data, br_taken, halted, fault, instret
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: FETCH/EXEC/HALT flow, branch/JAL/JALR resolution, link strobe, retire count.
// Optional macro MISALIGN_TRAP_EN: misaligned taken targets halt with fault instead of being truncated.
module pc_seq_ctrl #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [6:0]      HALT_OPC = 7'h7f
) (
    input logic           clk,
    input logic           rst,
    pc_seq_ctrl_if.master bus
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instret_q;
    logic [31:0]     link_data_q;
    logic            link_we_q;
    logic            br_taken_q;
    logic            halted_q;
    logic            fault_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jalr_sum;
    logic [PC_W-1:0] raw_target;
    logic [PC_W-1:0] target;
    logic            branch_cond;
    logic            is_halt;
    logic            redirect;
    logic            link;
    logic            misalign;
    logic            unused_bits;

    assign opcode    = bus.instr[6:0];
    assign funct3    = bus.instr[14:12];
    assign pc_plus4  = pc_q + PC_W'(4);
    assign br_target = pc_q + bus.imm[PC_W-1:0];
    assign jalr_sum  = bus.rs1_val[PC_W-1:0] + bus.imm[PC_W-1:0];

    assign unused_bits = ^{bus.instr[31:15], bus.instr[11:7],
                           bus.imm[31:PC_W], bus.rs1_val[31:PC_W]};

    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            3'b000:  branch_cond = bus.alu_zero;
            3'b001:  branch_cond = !bus.alu_zero;
            3'b100:  branch_cond = bus.alu_lt;
            3'b101:  branch_cond = !bus.alu_lt;
            3'b110:  branch_cond = bus.alu_ltu;
            3'b111:  branch_cond = !bus.alu_ltu;
            default: branch_cond = 1'b0;
        endcase
    end

    // Halt opcode is checked first so a custom HALT_OPC always wins over the decode below.
    always_comb begin
        is_halt    = 1'b0;
        redirect   = 1'b0;
        link       = 1'b0;
        raw_target = br_target;
        if (opcode == HALT_OPC) begin
            is_halt = 1'b1;
        end else begin
            case (opcode)
                OPC_BRANCH: begin
                    redirect   = branch_cond;
                    raw_target = br_target;
                end
                OPC_JAL: begin
                    redirect   = 1'b1;
                    link       = 1'b1;
                    raw_target = br_target;
                end
                OPC_JALR: begin
                    redirect   = 1'b1;
                    link       = 1'b1;
                    raw_target = {jalr_sum[PC_W-1:1], 1'b0};
                end
                default: begin
                    redirect   = 1'b0;
                    link       = 1'b0;
                    raw_target = br_target;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = redirect && (raw_target[1:0] != 2'b00);
    assign target   = raw_target;
`else
    assign misalign = 1'b0;
    assign target   = raw_target & ~PC_W'(3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc_q        <= RESET_PC;
            instret_q   <= '0;
            link_data_q <= '0;
            link_we_q   <= 1'b0;
            br_taken_q  <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            link_we_q  <= 1'b0;
            br_taken_q <= 1'b0;
            case (state)
                FETCH: begin
                    state <= EXEC;
                end
                EXEC: begin
                    // A stalled instruction has no side effects at all, including a pending halt.
                    if (!bus.stall) begin
                        if (is_halt) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end else if (misalign) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                            fault_q  <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            pc_q        <= redirect ? target : pc_plus4;
                            br_taken_q  <= redirect;
                            link_we_q   <= link;
                            link_data_q <= 32'(pc_plus4);
                            instret_q   <= instret_q + 32'd1;
                        end
                    end
                end
                HALT: begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign bus.imem_addr = pc_q[PC_W-1:2];
    assign bus.pc        = pc_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_data = link_data_q;
    assign bus.br_taken  = br_taken_q;
    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;
    assign bus.instret   = instret_q;

endmodule
